// File: rtl/scratch_mem_if.sv
// Scratch-memory bus between the engine-side mux (master) and the scratch memory (slave).
// Carries two read ports, one write port and the clear-sweep handshake.
interface scratch_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 20
);
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;
  logic [ADDR_W-1:0] raddr0;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              WE;

  modport master (
    output clear_start, raddr0, raddr1, waddr, wdata, WE,
    input  clear_busy, clear_done, rdata0, rdata1
  );

  modport slave (
    input  clear_start, raddr0, raddr1, waddr, wdata, WE,
    output clear_busy, clear_done, rdata0, rdata1
  );
endinterface

// File: rtl/scratch_mem.sv
// Dual-read, single-write scratch memory with registered, write-first read ports
// and a hardware sweep that zeroes every word before a new histogram pass.
module scratch_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 20,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  scratch_mem_if.slave bus
);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clear_done_q, clear_done_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic sweep_last;
  assign sweep_last = (clr_ptr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    state_d      = state_q;
    clr_ptr_d    = '0;
    clear_done_d = 1'b0;
    rdata0_d     = '0;
    rdata1_d     = '0;
    mem_we       = 1'b0;
    mem_waddr    = bus.waddr;
    mem_wdata    = bus.wdata;

    case (state_q)
      ST_IDLE: begin
        mem_we   = bus.WE;
        rdata0_d = (bus.WE && (bus.waddr == bus.raddr0)) ? bus.wdata : mem_q[bus.raddr0];
        rdata1_d = (bus.WE && (bus.waddr == bus.raddr1)) ? bus.wdata : mem_q[bus.raddr1];
        if (bus.clear_start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        // The sweep owns the write port; engine writes are dropped, reads return zero.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (sweep_last) begin
          state_d      = ST_IDLE;
          clr_ptr_d    = '0;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      clr_ptr_q    <= '0;
      clear_done_q <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      clear_done_q <= clear_done_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // NOTE: the array has no reset so it maps onto plain storage; only the sweep zeroes it.
  // Reset still blocks the write in its own cycle, so a sweep cut short leaves the hit word intact.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.clear_busy = (state_q == ST_CLEAR);
  assign bus.clear_done = clear_done_q;

endmodule

// File: tb/tb_scratch_mem.sv
// Self-checking bench for scratch_mem: vector table, hand-written clear/reset sequences,
// and randomized traffic compared against an array model of the memory.
module tb_scratch_mem;

  logic clk;
  logic reset;

  scratch_mem_if #(.ADDR_W(8), .DATA_W(20)) bus ();

  scratch_mem #(.ADDR_W(8), .DATA_W(20)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [7:0]  waddr;
    logic [19:0] wdata;
    logic [7:0]  r0;
    logic [7:0]  r1;
    logic [19:0] e0;
    logic [19:0] e1;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [19:0] model [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload_identity();
    for (int a = 0; a < 256; a++) begin
      bus.WE    = 1'b1;
      bus.waddr = 8'(a);
      bus.wdata = 20'(a);
      model[a]  = 20'(a);
      step();
    end
    bus.WE = 1'b0;
  endtask

  task automatic readback_all(input string name);
    for (int a = 0; a < 256; a += 2) begin
      bus.raddr0 = 8'(a);
      bus.raddr1 = 8'(a + 1);
      step();
      check(name, {12'h0, bus.rdata0}, {12'h0, model[a]});
      check(name, {12'h0, bus.rdata1}, {12'h0, model[a+1]});
    end
  endtask

  initial begin
    vec_t        tbl [9];
    int          busy_cycles;
    int          done_cnt;
    int          zero_bad;
    logic        we_r;
    logic [7:0]  wa_r, ra0_r, ra1_r;
    logic [19:0] wd_r, exp0, exp1;

    // ---------------- reset ----------------
    reset           = 1'b1;
    bus.clear_start = 1'b0;
    bus.WE          = 1'b1;
    bus.waddr       = 8'd0;
    bus.wdata       = 20'h5;
    bus.raddr0      = 8'd0;
    bus.raddr1      = 8'd0;
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_rdata0", {12'h0, bus.rdata0}, 32'h0);
      check("rst_rdata1", {12'h0, bus.rdata1}, 32'h0);
      check("rst_busy", {31'h0, bus.clear_busy}, 32'h0);
      check("rst_done", {31'h0, bus.clear_done}, 32'h0);
    end
    bus.WE = 1'b0;
    reset  = 1'b0;
    #1;
    check("post_rst_rdata0", {12'h0, bus.rdata0}, 32'h0);
    check("post_rst_rdata1", {12'h0, bus.rdata1}, 32'h0);
    check("post_rst_busy", {31'h0, bus.clear_busy}, 32'h0);
    check("post_rst_done", {31'h0, bus.clear_done}, 32'h0);

    // ---------------- full clear with dropped write and ignored restart ----------------
    preload_identity();
    readback_all("preload");
    bus.raddr0      = 8'd200;
    bus.raddr1      = 8'd17;
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    busy_cycles = 0;
    done_cnt    = 0;
    zero_bad    = 0;
    while (bus.clear_busy && busy_cycles < 300) begin
      busy_cycles++;
      if (bus.clear_done) done_cnt++;
      if (busy_cycles >= 2 && (bus.rdata0 != 20'h0 || bus.rdata1 != 20'h0)) zero_bad++;
      bus.WE          = (busy_cycles == 5);
      bus.waddr       = 8'd3;
      bus.wdata       = 20'h777;
      bus.clear_start = (busy_cycles == 10);
      step();
    end
    bus.WE          = 1'b0;
    bus.clear_start = 1'b0;
    check("clear_busy_cycles", busy_cycles, 256);
    check("done_during_busy", done_cnt, 0);
    check("rdata_zero_in_clear", zero_bad, 0);
    check("clear_done_pulse", {31'h0, bus.clear_done}, 32'h1);
    check("busy_low_at_done", {31'h0, bus.clear_busy}, 32'h0);
    check("last_clear_rdata0", {12'h0, bus.rdata0}, 32'h0);
    check("last_clear_rdata1", {12'h0, bus.rdata1}, 32'h0);
    for (int a = 0; a < 256; a++) model[a] = 20'h0;
    bus.raddr0 = 8'd3;
    bus.raddr1 = 8'd128;
    step();
    check("read_after_done_0", {12'h0, bus.rdata0}, 32'h0);
    check("read_after_done_1", {12'h0, bus.rdata1}, 32'h0);
    check("done_single_pulse", {31'h0, bus.clear_done}, 32'h0);
    check("no_restart", {31'h0, bus.clear_busy}, 32'h0);
    readback_all("cleared");

    // ---------------- vector table on a zeroed array ----------------
    tbl[0] = '{1'b1, 8'd5,   20'h00ABC, 8'd1,   8'd2,   20'h00000, 20'h00000};
    tbl[1] = '{1'b1, 8'd255, 20'hFFFFF, 8'd5,   8'd4,   20'h00ABC, 20'h00000};
    tbl[2] = '{1'b0, 8'd0,   20'h00000, 8'd5,   8'd255, 20'h00ABC, 20'hFFFFF};
    tbl[3] = '{1'b1, 8'd7,   20'h00001, 8'd0,   8'd0,   20'h00000, 20'h00000};
    tbl[4] = '{1'b1, 8'd7,   20'h12345, 8'd7,   8'd7,   20'h12345, 20'h12345};
    tbl[5] = '{1'b0, 8'd7,   20'h0FFFF, 8'd7,   8'd5,   20'h12345, 20'h00ABC};
    tbl[6] = '{1'b1, 8'd9,   20'hFFFFF, 8'd9,   8'd8,   20'hFFFFF, 20'h00000};
    tbl[7] = '{1'b1, 8'd8,   20'h55555, 8'd9,   8'd8,   20'hFFFFF, 20'h55555};
    tbl[8] = '{1'b0, 8'd0,   20'h00000, 8'd8,   8'd9,   20'h55555, 20'hFFFFF};
    for (int i = 0; i < 9; i++) begin
      bus.WE     = tbl[i].we;
      bus.waddr  = tbl[i].waddr;
      bus.wdata  = tbl[i].wdata;
      bus.raddr0 = tbl[i].r0;
      bus.raddr1 = tbl[i].r1;
      if (tbl[i].we) model[tbl[i].waddr] = tbl[i].wdata;
      step();
      check($sformatf("vec%0d_rdata0", i), {12'h0, bus.rdata0}, {12'h0, tbl[i].e0});
      check($sformatf("vec%0d_rdata1", i), {12'h0, bus.rdata1}, {12'h0, tbl[i].e1});
    end
    bus.WE = 1'b0;

    // ---------------- randomized traffic against the array model ----------------
    for (int i = 0; i < 400; i++) begin
      we_r  = 1'($urandom_range(0, 1));
      wa_r  = (i % 5 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      wd_r  = 20'($urandom);
      ra0_r = 8'($urandom_range(0, 15));
      ra1_r = ($urandom_range(0, 3) == 0) ? ra0_r : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) ra0_r = wa_r;
      exp0 = (we_r && wa_r == ra0_r) ? wd_r : model[ra0_r];
      exp1 = (we_r && wa_r == ra1_r) ? wd_r : model[ra1_r];
      if (we_r) model[wa_r] = wd_r;
      bus.WE     = we_r;
      bus.waddr  = wa_r;
      bus.wdata  = wd_r;
      bus.raddr0 = ra0_r;
      bus.raddr1 = ra1_r;
      step();
      check("rand_rdata0", {12'h0, bus.rdata0}, {12'h0, exp0});
      check("rand_rdata1", {12'h0, bus.rdata1}, {12'h0, exp1});
    end
    bus.WE = 1'b0;
    readback_all("rand_final");

    // ---------------- reset in the 100th busy cycle ----------------
    preload_identity();
    bus.raddr0      = 8'd0;
    bus.raddr1      = 8'd0;
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    busy_cycles = 0;
    done_cnt    = 0;
    while (bus.clear_busy && busy_cycles < 100) begin
      busy_cycles++;
      if (bus.clear_done) done_cnt++;
      if (busy_cycles == 100) break;
      step();
    end
    check("busy_before_reset", busy_cycles, 100);
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check("midrst_busy", {31'h0, bus.clear_busy}, 32'h0);
      if (bus.clear_done) done_cnt++;
    end
    reset = 1'b0;
    for (int a = 0; a < 99; a++) model[a] = 20'h0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.clear_done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    readback_all("midrst_contents");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
